can_bit_timer: RTL

- CAN bit-timing controller. Sequences a programmable time-quantum (tq) prescaler and a bit-segment state machine: SYNC, then SEG1 (prop + phase1), then SEG2.
- Issues bit-start and sample-point strobes to the CAN MAC.
- Performs SJW-limited soft resynchronisation on recessive-to-dominant rx edges.
- Sits between the 50 MHz system clock and the CAN bit stream; replaces free-running dividers for bit timing.

---
 rtl/can_bit_timer_if.sv | 51 +++++
 rtl/can_bit_timer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/can_bit_timer_if.sv
// ============================================================================
// Module   : can_bit_timer_if
// Purpose  : Configuration, rx and strobe bundle between CAN MAC and bit timer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface can_bit_timer_if #(
  parameter int PRESC_W = 10,
  parameter int SEG1_W  = 4,
  parameter int SEG2_W  = 3,
  parameter int SJW_W   = 2
);
  logic               enable;
  logic [PRESC_W-1:0] brp;
  logic [SEG1_W-1:0]  tseg1;
  logic [SEG2_W-1:0]  tseg2;
  logic [SJW_W-1:0]   sjw;
  logic               rx;
`ifdef CAN_BIT_TIMER_HARD_SYNC_EN
  logic               hard_sync;
`endif
  logic               tq_tick;
  logic               bit_start;
  logic               sample_pt;
  logic               sampled_bit;
  logic [1:0]         seg_state;
  logic               busy;

`ifdef CAN_BIT_TIMER_HARD_SYNC_EN
  modport master (
    output enable, brp, tseg1, tseg2, sjw, rx, hard_sync,
    input  tq_tick, bit_start, sample_pt, sampled_bit, seg_state, busy
  );
  modport slave (
    input  enable, brp, tseg1, tseg2, sjw, rx, hard_sync,
    output tq_tick, bit_start, sample_pt, sampled_bit, seg_state, busy
  );
`else
  modport master (
    output enable, brp, tseg1, tseg2, sjw, rx,
    input  tq_tick, bit_start, sample_pt, sampled_bit, seg_state, busy
  );
  modport slave (
    input  enable, brp, tseg1, tseg2, sjw, rx,
    output tq_tick, bit_start, sample_pt, sampled_bit, seg_state, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/can_bit_timer.sv
// ============================================================================
// Module   : can_bit_timer
// Purpose  : CAN bit timing: tq prescaler, SYNC/SEG1/SEG2 sequencing and
//            SJW-limited soft resync. Hard sync via CAN_BIT_TIMER_HARD_SYNC_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module can_bit_timer #(
  parameter int PRESC_W = 10,
  parameter int SEG1_W  = 4,
  parameter int SEG2_W  = 3,
  parameter int SJW_W   = 2
) (
  input  wire logic          clk50Mhz,
  input  wire logic          rst,
  can_bit_timer_if.slave     bt
);
  // One extra bit so SEG1 can be stretched beyond tseg1 by a late resync.
  localparam int CNT_W = SEG1_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_SEG1 = 2'd2,
    ST_SEG2 = 2'd3
  } state_t;

  state_t             r_state, w_state_n;
  logic [PRESC_W-1:0] r_presc, w_presc_n, r_brp_l, w_brp_n;
  logic [SEG1_W-1:0]  r_tseg1_l, w_tseg1_n;
  logic [SEG2_W-1:0]  r_tseg2_l, w_tseg2_n;
  logic [SJW_W-1:0]   r_sjw_l, w_sjw_n;
  logic [CNT_W-1:0]   r_seg_cnt, w_seg_cnt_n;
  logic [CNT_W-1:0]   r_seg1_end, w_seg1_end_n, r_seg2_end, w_seg2_end_n;
  logic               r_resync_done, w_resync_n;
  logic               r_rx_prev;
  logic               r_sampled_bit, w_sampled_n;

  logic               w_active, w_tq_tick, w_edge, w_hard, w_soft;
  logic [CNT_W-1:0]   w_sjw1, w_late_e, w_late_add, w_early_r, w_early_sub;
  logic [CNT_W-1:0]   w_seg1_end_eff, w_seg2_end_eff;

  assign w_active  = (r_state != ST_IDLE);
  assign w_tq_tick = w_active && (r_presc == r_brp_l);
  assign w_edge    = r_rx_prev & ~bt.rx;

`ifdef CAN_BIT_TIMER_HARD_SYNC_EN
  assign w_hard = w_edge && w_active && bt.hard_sync;
`else
  assign w_hard = 1'b0;
`endif

  assign w_soft = w_edge && !r_resync_done && !w_hard &&
                  ((r_state == ST_SEG1) || (r_state == ST_SEG2));

  // Segment ends including an edge arriving in this very clock.
  assign w_sjw1      = CNT_W'(r_sjw_l) + CNT_W'(1);
  assign w_late_e    = r_seg_cnt + CNT_W'(1);
  assign w_late_add  = (w_late_e < w_sjw1) ? w_late_e : w_sjw1;
  assign w_early_r   = r_seg2_end - r_seg_cnt;
  assign w_early_sub = (w_early_r < w_sjw1) ? w_early_r : w_sjw1;

  assign w_seg1_end_eff = r_seg1_end +
      ((w_soft && (r_state == ST_SEG1)) ? w_late_add : CNT_W'(0));
  assign w_seg2_end_eff = r_seg2_end -
      ((w_soft && (r_state == ST_SEG2)) ? w_early_sub : CNT_W'(0));

  assign bt.tq_tick     = w_tq_tick;
  assign bt.bit_start   = ((r_state == ST_SYNC) && (r_presc == '0)) || w_hard;
  assign bt.sample_pt   = (r_state == ST_SEG1) && w_tq_tick &&
                          (r_seg_cnt == w_seg1_end_eff) && !w_hard;
  assign bt.sampled_bit = r_sampled_bit;
  assign bt.seg_state   = r_state;
  assign bt.busy        = w_active;

  always_comb begin
    w_state_n    = r_state;
    w_presc_n    = (w_active && !w_tq_tick) ? r_presc + PRESC_W'(1) : '0;
    w_brp_n      = r_brp_l;
    w_tseg1_n    = r_tseg1_l;
    w_tseg2_n    = r_tseg2_l;
    w_sjw_n      = r_sjw_l;
    w_seg_cnt_n  = r_seg_cnt;
    w_seg1_end_n = r_seg1_end;
    w_seg2_end_n = r_seg2_end;
    w_resync_n   = r_resync_done;
    w_sampled_n  = r_sampled_bit;

    case (r_state)
      ST_IDLE: begin
        if (bt.enable) begin
          w_state_n   = ST_SYNC;
          w_seg_cnt_n = '0;
          w_brp_n     = bt.brp;
          w_tseg1_n   = bt.tseg1;
          w_tseg2_n   = bt.tseg2;
          w_sjw_n     = bt.sjw;
          w_resync_n  = 1'b0;
        end
      end
      ST_SYNC: begin
        if (w_tq_tick) begin
          w_state_n    = ST_SEG1;
          w_seg_cnt_n  = '0;
          w_seg1_end_n = CNT_W'(r_tseg1_l);
        end
      end
      ST_SEG1: begin
        w_seg1_end_n = w_seg1_end_eff;
        if (w_soft) w_resync_n = 1'b1;
        if (w_tq_tick) begin
          if (r_seg_cnt == w_seg1_end_eff) begin
            w_state_n    = ST_SEG2;
            w_seg_cnt_n  = '0;
            w_seg2_end_n = CNT_W'(r_tseg2_l);
            w_sampled_n  = bt.rx;
          end else begin
            w_seg_cnt_n = r_seg_cnt + CNT_W'(1);
          end
        end
      end
      ST_SEG2: begin
        w_seg2_end_n = w_seg2_end_eff;
        if (w_soft) w_resync_n = 1'b1;
        if (w_tq_tick) begin
          if (r_seg_cnt == w_seg2_end_eff) begin
            w_state_n   = ST_SYNC;
            w_seg_cnt_n = '0;
            w_brp_n     = bt.brp;
            w_tseg1_n   = bt.tseg1;
            w_tseg2_n   = bt.tseg2;
            w_sjw_n     = bt.sjw;
            w_resync_n  = 1'b0;
          end else begin
            w_seg_cnt_n = r_seg_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase

    // The edge clock itself serves as the SYNC tq.
    if (w_hard) begin
      w_state_n    = ST_SEG1;
      w_presc_n    = '0;
      w_seg_cnt_n  = '0;
      w_seg1_end_n = CNT_W'(r_tseg1_l);
      w_resync_n   = 1'b1;
      w_sampled_n  = r_sampled_bit;
    end

    if (w_active && !bt.enable) begin
      w_state_n   = ST_IDLE;
      w_presc_n   = '0;
      w_seg_cnt_n = '0;
    end
  end

  always_ff @(posedge clk50Mhz) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_presc       <= '0;
      r_brp_l       <= '0;
      r_tseg1_l     <= '0;
      r_tseg2_l     <= '0;
      r_sjw_l       <= '0;
      r_seg_cnt     <= '0;
      r_seg1_end    <= '0;
      r_seg2_end    <= '0;
      r_resync_done <= 1'b0;
      r_rx_prev     <= 1'b1;
      r_sampled_bit <= 1'b1;
    end else begin
      r_state       <= w_state_n;
      r_presc       <= w_presc_n;
      r_brp_l       <= w_brp_n;
      r_tseg1_l     <= w_tseg1_n;
      r_tseg2_l     <= w_tseg2_n;
      r_sjw_l       <= w_sjw_n;
      r_seg_cnt     <= w_seg_cnt_n;
      r_seg1_end    <= w_seg1_end_n;
      r_seg2_end    <= w_seg2_end_n;
      r_resync_done <= w_resync_n;
      r_rx_prev     <= bt.rx;
      r_sampled_bit <= w_sampled_n;
    end
  end

endmodule

`default_nettype wire
